gray_counter_param: RTL and testbench

Parametrised Gray-code counter. It generalises the fixed 4-bit free-running Gray counter to any width, and adds:
- enable
- up/down direction
- synchronous load
- wrap or saturate mode at the range ends
- a wrap pulse
All outputs are registered, so the Gray output is glitch-free. It can safely feed CDC pointer logic such as async FIFO pointers.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray2bin_conv.sv | 14 +
 rtl/gray_counter_param.sv | 92 +++++++++
 tb/tb_gray_counter_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and pointer synchronisers.
// The functions work on GRAY_MAX_WIDTH bits. Narrower values are zero-extended on the way in and truncated on the way out.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;
  localparam int GRAY_MIN_WIDTH = 2;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the low bits unchanged.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter.
// It is usable on its own, for example in synchronised FIFO pointer paths.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray)));

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised Gray counter with enable, direction, load and wrap/saturate limits.
// All outputs come straight from flops, so gray_out is glitch-free for CDC use.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RST_VAL)));
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  if (WIDTH < GRAY_MIN_WIDTH || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
    $error("gray_counter_param: WIDTH out of range");
  end

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] load_bin_s;
  logic [WIDTH-1:0] bin_nxt_s;
  logic [WIDTH-1:0] gray_nxt_s;
  logic             wrap_nxt_s;

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
    .gray (load_gray),
    .bin  (load_bin_s)
  );

  // Next-state selection: load beats count, and the range ends either wrap or hold.
  always_comb begin
    bin_nxt_s  = bin_r;
    gray_nxt_s = gray_out;
    wrap_nxt_s = 1'b0;
    if (load) begin
      bin_nxt_s  = load_bin_s;
      gray_nxt_s = load_gray;
    end else if (en) begin
      if (up_dn) begin
        if (bin_r != ALL_ONES) begin
          bin_nxt_s = bin_r + ONE;
        end else if (!SATURATE) begin
          bin_nxt_s  = ZERO;
          wrap_nxt_s = 1'b1;
        end else begin
          bin_nxt_s = bin_r;
        end
      end else begin
        if (bin_r != ZERO) begin
          bin_nxt_s = bin_r - ONE;
        end else if (!SATURATE) begin
          bin_nxt_s  = ALL_ONES;
          wrap_nxt_s = 1'b1;
        end else begin
          bin_nxt_s = bin_r;
        end
      end
      gray_nxt_s = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_nxt_s)));
    end else begin
      bin_nxt_s  = bin_r;
      gray_nxt_s = gray_out;
    end
  end

  // State and output registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_r    <= RST_BIN;
      gray_out <= RST_GRAY;
      wrap     <= 1'b0;
    end else begin
      bin_r    <= bin_nxt_s;
      gray_out <= gray_nxt_s;
      wrap     <= wrap_nxt_s;
    end
  end

  assign bin_out = bin_r;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param with three configurations on shared stimulus:
// wrap/RST_VAL=0, saturate/RST_VAL=0 and wrap/RST_VAL=5.
module tb_gray_counter_param;

  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, load;
  logic [3:0] load_gray;
  logic [3:0] gray_a, bin_a, gray_b, bin_b, gray_c, bin_c;
  logic       wrap_a, wrap_b, wrap_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] g[3];
    logic [3:0] b[3];
    logic       w[3];
    logic       stepped_a;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_bin[3];
  logic [3:0] prev_gray_a;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .gray_out(gray_a), .bin_out(bin_a), .wrap(wrap_a));

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .gray_out(gray_b), .bin_out(bin_b), .wrap(wrap_b));

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .gray_out(gray_c), .bin_out(bin_c), .wrap(wrap_c));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive one cycle of inputs, predict the outputs of all three DUTs, then compare after the edge.
  task automatic step(input logic r, input logic l, input logic [3:0] lg,
                      input logic e, input logic u, input string tag);
    exp_t       x, y;
    logic       sat;
    logic [3:0] rv;
    logic [3:0] old;
    rst_n = r; load = l; load_gray = lg; en = e; up_dn = u;
    x.tag = tag;
    x.stepped_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sat = (k == 1);
      rv  = (k == 2) ? 4'd5 : 4'd0;
      old = m_bin[k];
      x.w[k] = 1'b0;
      if (!r) m_bin[k] = rv;
      else if (l) m_bin[k] = g2b(lg);
      else if (e && u) begin
        if (old == 4'hF) begin
          if (!sat) begin m_bin[k] = 4'h0; x.w[k] = 1'b1; end
        end else m_bin[k] = old + 4'd1;
      end else if (e && !u) begin
        if (old == 4'h0) begin
          if (!sat) begin m_bin[k] = 4'hF; x.w[k] = 1'b1; end
        end else m_bin[k] = old - 4'd1;
      end
      x.b[k] = m_bin[k];
      x.g[k] = m_bin[k] ^ (m_bin[k] >> 1);
      if (k == 0 && r && !l && e && m_bin[k] != old) x.stepped_a = 1'b1;
    end
    sb.push_back(x);
    prev_gray_a = gray_a;
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk({y.tag, "_gray_a"}, gray_a, y.g[0]);
    chk({y.tag, "_bin_a"},  bin_a,  y.b[0]);
    chk({y.tag, "_wrap_a"}, {3'b000, wrap_a}, {3'b000, y.w[0]});
    chk({y.tag, "_gray_b"}, gray_b, y.g[1]);
    chk({y.tag, "_bin_b"},  bin_b,  y.b[1]);
    chk({y.tag, "_wrap_b"}, {3'b000, wrap_b}, {3'b000, y.w[1]});
    chk({y.tag, "_gray_c"}, gray_c, y.g[2]);
    chk({y.tag, "_bin_c"},  bin_c,  y.b[2]);
    chk({y.tag, "_wrap_c"}, {3'b000, wrap_c}, {3'b000, y.w[2]});
    if (y.stepped_a) chk({y.tag, "_onebit_a"}, 4'($countones(prev_gray_a ^ gray_a)), 4'd1);
  endtask

  logic [3:0] gray_tab[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_gray = 4'h0;
    for (int k = 0; k < 3; k++) m_bin[k] = 4'h0;

    // 1: reset held for two cycles with en high
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "reset");
      chk("reset_gray_a", gray_a, 4'b0000);
      chk("reset_wrap_a", {3'b000, wrap_a}, 4'd0);
      chk("reset_gray_c", gray_c, 4'b0111);
    end

    // 2: count up through the full range and wrap
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "up");
      chk("up_seq_a", gray_a, gray_tab[i % 16]);
      chk("up_wrap_a", {3'b000, wrap_a}, (i == 16) ? 4'd1 : 4'd0);
    end
    chk("sat_top_b", gray_b, 4'b1000);

    // 3: down from zero wraps to all-ones, then hold
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, "down_wrap");
    chk("down_gray_a", gray_a, 4'b1000);
    chk("down_bin_a", bin_a, 4'b1111);
    chk("down_wrap_a", {3'b000, wrap_a}, 4'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "hold");
      chk("hold_gray_a", gray_a, 4'b1000);
      chk("hold_wrap_a", {3'b000, wrap_a}, 4'd0);
    end

    // 4: load wins over en, then count up from the loaded value
    step(1'b1, 1'b1, 4'b1100, 1'b1, 1'b0, "load");
    chk("load_gray_a", gray_a, 4'b1100);
    chk("load_bin_a", bin_a, 4'b1000);
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "after_load");
    chk("after_load_gray_a", gray_a, 4'b1101);
    chk("after_load_bin_a", bin_a, 4'b1001);

    // 5: saturation at the top, then step down
    step(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, "load_max");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "sat_up");
      chk("sat_gray_b", gray_b, 4'b1000);
      chk("sat_wrap_b", {3'b000, wrap_b}, 4'd0);
    end
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, "sat_down");
    chk("sat_down_gray_b", gray_b, 4'b1001);
    chk("sat_down_bin_b", bin_b, 4'd14);

    // 6: reset mid-count with en high
    step(1'b1, 1'b1, 4'b0101, 1'b0, 1'b1, "load6");
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "mid_reset");
    chk("mid_reset_gray_a", gray_a, 4'b0000);
    chk("mid_reset_wrap_a", {3'b000, wrap_a}, 4'd0);
    chk("mid_reset_gray_c", gray_c, 4'b0111);
    chk("mid_reset_bin_c", bin_c, 4'b0101);
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "post_reset");
    step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, "post_reset_down");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
